i2c_target_regs: RTL and testbench

- I2C target (responder) that answers the system's I2C host on the same open-drain bus.
- Exposes a small byte-wide register file, used for game/puck status and control, on the bus. Host writes set a register pointer, then write or read bytes with auto-increment.
- Fabric side can update registers locally and receives a strobe for every host write.
- Sits in the FPGA fabric beside the soft processor. No clock stretching.

---
 rtl/i2c_target_regs.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file with an auto-incrementing pointer.
// Fabric side gets a combinational read port, a local write port and a strobe per host write.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h28,
    parameter int         NUM_REGS    = 8,
    parameter int         AW          = $clog2(NUM_REGS)
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          i2c_serial_sda_in,
    input  logic          i2c_serial_scl_in,
    output logic          i2c_serial_sda_oe,
    output logic          i2c_serial_scl_oe,
    input  logic          lcl_wr_en,
    input  logic [AW-1:0] lcl_addr,
    input  logic [7:0]    lcl_wdata,
    input  logic [AW-1:0] lcl_rd_addr,
    output logic [7:0]    lcl_rd_data,
    output logic          host_wr_valid,
    output logic [AW-1:0] host_wr_addr,
    output logic [7:0]    host_wr_data,
    output logic          busy,
    output logic [3:0]    dbg_state
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_ADDR_ACK = 4'd2;
    localparam logic [3:0] S_PTR      = 4'd3;
    localparam logic [3:0] S_PTR_ACK  = 4'd4;
    localparam logic [3:0] S_WR_DATA  = 4'd5;
    localparam logic [3:0] S_WR_ACK   = 4'd6;
    localparam logic [3:0] S_RD_DATA  = 4'd7;
    localparam logic [3:0] S_RD_ACK   = 4'd8;
    localparam logic [3:0] S_IGNORE   = 4'd9;

    logic [7:0]    regs [NUM_REGS];
    logic          sda_s1, sda_s2, sda_d;
    logic          scl_s1, scl_s2, scl_d;
    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [7:0]    tx_byte;
    logic [AW-1:0] ptr;
    logic          rd_mode;

    logic          scl_rise, scl_fall, start_det, stop_det, byte_done, ptr_ok;
    logic [7:0]    rx_next;

    // Synchronizers idle high so reset release never looks like a bus condition.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
        end else begin
            sda_s1 <= i2c_serial_sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
            scl_s1 <= i2c_serial_scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_next   = {shift_reg[6:0], sda_s2};
    assign byte_done = (bit_cnt == 4'd7);
    assign ptr_ok    = ((rx_next >> AW) == 8'd0);

    // In ACK states sda_oe doubles as the phase flag: first fall drives, second fall releases.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state             <= S_IDLE;
            bit_cnt           <= '0;
            shift_reg         <= '0;
            tx_byte           <= '0;
            ptr               <= '0;
            rd_mode           <= 1'b0;
            i2c_serial_sda_oe <= 1'b0;
            busy              <= 1'b0;
            host_wr_valid     <= 1'b0;
            host_wr_addr      <= '0;
            host_wr_data      <= '0;
        end else begin
            host_wr_valid <= 1'b0;
            if (start_det) begin
                state             <= S_ADDR;
                bit_cnt           <= '0;
                i2c_serial_sda_oe <= 1'b0;
            end else if (stop_det) begin
                state             <= S_IDLE;
                i2c_serial_sda_oe <= 1'b0;
                busy              <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        shift_reg <= rx_next;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            if (rx_next[7:1] == TARGET_ADDR) begin
                                state   <= S_ADDR_ACK;
                                busy    <= 1'b1;
                                rd_mode <= rx_next[0];
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (!i2c_serial_sda_oe) begin
                            i2c_serial_sda_oe <= 1'b1;
                        end else if (rd_mode) begin
                            tx_byte           <= regs[ptr];
                            i2c_serial_sda_oe <= ~regs[ptr][7];
                            state             <= S_RD_DATA;
                        end else begin
                            i2c_serial_sda_oe <= 1'b0;
                            state             <= S_PTR;
                        end
                    end
                    S_PTR: if (scl_rise) begin
                        shift_reg <= rx_next;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            if (ptr_ok) begin
                                ptr   <= rx_next[AW-1:0];
                                state <= S_PTR_ACK;
                            end else begin
                                state <= S_IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (!i2c_serial_sda_oe) begin
                            i2c_serial_sda_oe <= 1'b1;
                        end else begin
                            i2c_serial_sda_oe <= 1'b0;
                            state             <= S_WR_DATA;
                        end
                    end
                    S_WR_DATA: if (scl_rise) begin
                        shift_reg <= rx_next;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (byte_done) begin
                            host_wr_valid <= 1'b1;
                            host_wr_addr  <= ptr;
                            host_wr_data  <= rx_next;
                            ptr           <= ptr + AW'(1);
                            state         <= S_WR_ACK;
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                i2c_serial_sda_oe <= 1'b0;
                                state             <= S_RD_ACK;
                            end else begin
                                tx_byte           <= {tx_byte[6:0], 1'b0};
                                i2c_serial_sda_oe <= ~tx_byte[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr + AW'(1);
                            if (sda_s2) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            tx_byte           <= regs[ptr];
                            i2c_serial_sda_oe <= ~regs[ptr][7];
                            bit_cnt           <= '0;
                            state             <= S_RD_DATA;
                        end
                    end
                    default: i2c_serial_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Host write commits during its strobe cycle and overrides a same-index local write.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (lcl_wr_en) regs[lcl_addr] <= lcl_wdata;
            if (host_wr_valid) regs[host_wr_addr] <= host_wr_data;
        end
    end

    assign lcl_rd_data       = regs[lcl_rd_addr];
    assign i2c_serial_scl_oe = 1'b0;
    assign dbg_state         = state;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C host, local-port driver and a register-file model.
module tb_i2c_target_regs;
    localparam int NUM_REGS = 8;
    localparam int AW       = 3;
    localparam int Q        = 16;
    localparam int HOLD     = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sda_h = 1'b1;
    logic          scl_h = 1'b1;
    logic          lcl_wr_en = 1'b0;
    logic [AW-1:0] lcl_addr = '0;
    logic [7:0]    lcl_wdata = '0;
    logic [AW-1:0] lcl_rd_addr = '0;
    logic          sda_oe, scl_oe, host_wr_valid, busy;
    logic [AW-1:0] host_wr_addr;
    logic [7:0]    host_wr_data, lcl_rd_data;
    logic [3:0]    dbg_state;
    wire           sda_bus;

    assign sda_bus = sda_h & ~sda_oe;

    i2c_target_regs #(.TARGET_ADDR(7'h28), .NUM_REGS(NUM_REGS)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rst_n),
        .i2c_serial_sda_in (sda_bus),
        .i2c_serial_scl_in (scl_h),
        .i2c_serial_sda_oe (sda_oe),
        .i2c_serial_scl_oe (scl_oe),
        .lcl_wr_en         (lcl_wr_en),
        .lcl_addr          (lcl_addr),
        .lcl_wdata         (lcl_wdata),
        .lcl_rd_addr       (lcl_rd_addr),
        .lcl_rd_data       (lcl_rd_data),
        .host_wr_valid     (host_wr_valid),
        .host_wr_addr      (host_wr_addr),
        .host_wr_data      (host_wr_data),
        .busy              (busy),
        .dbg_state         (dbg_state)
    );

    // ---------------- model and scoreboard ----------------
    logic [7:0]    model_regs [NUM_REGS];
    int            model_ptr;
    logic [AW+7:0] exp_q [$];
    logic [AW+7:0] obs_mem [256];
    int            obs_cnt = 0;
    int            rd_idx = 0;
    int            oe_cnt = 0;
    int            oe_bad = 0;
    logic          oe_prev = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (host_wr_valid && obs_cnt < 256) begin
                obs_mem[obs_cnt] = {host_wr_addr, host_wr_data};
                obs_cnt++;
            end
            if (sda_oe) oe_cnt++;
            if (sda_oe && !oe_prev && scl_h) oe_bad++;
            oe_prev = sda_oe;
        end else begin
            oe_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_wr(input logic [7:0] b);
        model_regs[model_ptr] = b;
        exp_q.push_back({AW'(model_ptr), b});
        model_ptr = (model_ptr + 1) % NUM_REGS;
    endtask

    task automatic drain_check();
        chk("host_wr_count", obs_cnt - rd_idx, exp_q.size());
        while (rd_idx < obs_cnt && exp_q.size() > 0) begin
            chk("host_wr", 32'(obs_mem[rd_idx]), 32'(exp_q.pop_front()));
            rd_idx++;
        end
        exp_q.delete();
        rd_idx = obs_cnt;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            lcl_rd_addr = AW'(i);
            #1;
            chk(tag, lcl_rd_data, model_regs[i]);
            wait_clk(1);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic lcl_write(input logic [AW-1:0] idx, input logic [7:0] val);
        lcl_addr  = idx;
        lcl_wdata = val;
        lcl_wr_en = 1'b1;
        wait_clk(1);
        lcl_wr_en = 1'b0;
        model_regs[idx] = val;
    endtask

    task automatic i2c_start();
        sda_h = 1'b1; wait_clk(Q);
        scl_h = 1'b1; wait_clk(Q);
        sda_h = 1'b0; wait_clk(Q);
        scl_h = 1'b0; wait_clk(HOLD);
    endtask

    task automatic i2c_stop();
        sda_h = 1'b0; wait_clk(Q);
        scl_h = 1'b1; wait_clk(Q);
        sda_h = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_h = b;    wait_clk(Q);
        scl_h = 1'b1; wait_clk(Q);
        scl_h = 1'b0; wait_clk(HOLD);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic ack;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_h = 1'b1; wait_clk(Q);
        scl_h = 1'b1; wait_clk(Q / 2);
        ack = ~sda_bus;
        wait_clk(Q - Q / 2);
        scl_h = 1'b0; wait_clk(HOLD);
        chk(tag, ack, exp_ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        d = '0;
        sda_h = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_clk(Q);
            scl_h = 1'b1; wait_clk(Q / 2);
            d = {d[6:0], sda_bus};
            wait_clk(Q - Q / 2);
            scl_h = 1'b0; wait_clk(HOLD);
        end
        sda_h = ~ack; wait_clk(Q);
        scl_h = 1'b1; wait_clk(Q / 2);
        chk("host_ack_bit_released", sda_oe, 1'b0);
        wait_clk(Q - Q / 2);
        scl_h = 1'b0; wait_clk(HOLD);
        sda_h = 1'b1;
    endtask

    // Waits (bounded) for the next host write strobe and fires a local write in that cycle.
    task automatic collide(input logic [AW-1:0] idx, input logic [7:0] val);
        bit seen = 1'b0;
        for (int i = 0; i < 40 * Q && !seen; i++) begin
            wait_clk(1);
            if (host_wr_valid) begin
                seen      = 1'b1;
                lcl_addr  = idx;
                lcl_wdata = val;
                lcl_wr_en = 1'b1;
                wait_clk(1);
                lcl_wr_en = 1'b0;
            end
        end
        chk("collide_strobe_seen", seen, 1'b1);
    endtask

    task automatic do_write_txn(input logic [7:0] ptr_byte, input int n);
        bit         in_range;
        logic [7:0] b;
        in_range = (ptr_byte < NUM_REGS);
        i2c_start();
        send_byte(8'h50, 1'b1, "addr_w_ack");
        chk("busy_after_addr", busy, 1'b1);
        send_byte(ptr_byte, in_range, "ptr_ack");
        if (in_range) model_ptr = int'(ptr_byte);
        else chk("busy_cleared_ignore", busy, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (in_range) model_wr(b);
            send_byte(b, in_range, "data_ack");
        end
        i2c_stop();
        chk("busy_after_stop", busy, 1'b0);
        drain_check();
    endtask

    task automatic do_read_txn(input int n);
        logic [7:0] d;
        i2c_start();
        send_byte(8'h51, 1'b1, "addr_r_ack");
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d);
            chk("rd_data", d, model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % NUM_REGS;
        end
        i2c_stop();
        chk("busy_after_read", busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] d;
        int         hw_before, oe_before;

        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_ptr = 0;

        wait_clk(3);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_scl_oe", scl_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_host_wr_valid", host_wr_valid, 1'b0);
        chk("rst_host_wr_addr", host_wr_addr, 0);
        chk("rst_host_wr_data", host_wr_data, 8'h00);
        check_regs("rst_regs");
        rst_n = 1'b1;
        wait_clk(4);

        // Write burst; local write to index 3 collides with the host write of 0x3C.
        i2c_start();
        send_byte(8'h50, 1'b1, "burst_addr_ack");
        chk("burst_busy", busy, 1'b1);
        send_byte(8'h02, 1'b1, "burst_ptr_ack");
        model_ptr = 2;
        model_wr(8'hA5);
        send_byte(8'hA5, 1'b1, "burst_d0_ack");
        model_wr(8'h3C);
        fork
            send_byte(8'h3C, 1'b1, "burst_d1_ack");
            collide(3'd3, 8'h77);
        join
        i2c_stop();
        chk("burst_busy_after_stop", busy, 1'b0);
        drain_check();
        check_regs("burst_regs");

        // Combined read with repeated START.
        i2c_start();
        send_byte(8'h50, 1'b1, "comb_addr_ack");
        send_byte(8'h02, 1'b1, "comb_ptr_ack");
        i2c_start();
        send_byte(8'h51, 1'b1, "comb_addr_r_ack");
        read_byte(1'b1, d);
        chk("comb_rd0", d, 8'hA5);
        read_byte(1'b0, d);
        chk("comb_rd1", d, 8'h3C);
        model_ptr = 4;
        i2c_stop();
        chk("comb_busy_after_stop", busy, 1'b0);

        // Local write to index 4 in the same cycle as a host write to index 3.
        i2c_start();
        send_byte(8'h50, 1'b1, "col4_addr_ack");
        send_byte(8'h03, 1'b1, "col4_ptr_ack");
        model_ptr = 3;
        model_wr(8'h5A);
        fork
            send_byte(8'h5A, 1'b1, "col4_data_ack");
            collide(3'd4, 8'h6B);
        join
        model_regs[4] = 8'h6B;
        i2c_stop();
        drain_check();
        check_regs("col4_regs");

        // Address mismatch stays silent.
        oe_before = oe_cnt;
        hw_before = obs_cnt;
        i2c_start();
        send_byte(8'h52, 1'b0, "mismatch_addr_nack");
        chk("mismatch_busy", busy, 1'b0);
        send_byte(8'h00, 1'b0, "mismatch_b1_nack");
        send_byte(8'hFF, 1'b0, "mismatch_b2_nack");
        i2c_stop();
        chk("mismatch_oe_silent", oe_cnt - oe_before, 0);
        chk("mismatch_no_wr", obs_cnt - hw_before, 0);
        check_regs("mismatch_regs");

        // Pointer wrap.
        i2c_start();
        send_byte(8'h50, 1'b1, "wrap_addr_ack");
        send_byte(8'h07, 1'b1, "wrap_ptr_ack");
        model_ptr = 7;
        model_wr(8'h11);
        send_byte(8'h11, 1'b1, "wrap_d0_ack");
        model_wr(8'h22);
        send_byte(8'h22, 1'b1, "wrap_d1_ack");
        i2c_stop();
        drain_check();
        check_regs("wrap_regs");

        // Out-of-range pointer: NACK, following byte ignored.
        i2c_start();
        send_byte(8'h50, 1'b1, "range_addr_ack");
        send_byte(8'h09, 1'b0, "range_ptr_nack");
        chk("range_busy_ignore", busy, 1'b0);
        send_byte(8'h33, 1'b0, "range_data_nack");
        i2c_stop();
        drain_check();
        check_regs("range_regs");
        do_read_txn(2);

        // STOP after four bits of a data byte aborts it.
        lcl_write(3'd5, 8'hE7);
        i2c_start();
        send_byte(8'h50, 1'b1, "abort_addr_ack");
        send_byte(8'h05, 1'b1, "abort_ptr_ack");
        model_ptr = 5;
        hw_before = obs_cnt;
        write_bit(1'b0);
        write_bit(1'b0);
        write_bit(1'b0);
        write_bit(1'b1);
        i2c_stop();
        chk("abort_sda_released", sda_oe, 1'b0);
        chk("abort_no_wr", obs_cnt - hw_before, 0);
        do_read_txn(1);

        // Tx byte is a snapshot: a local write mid-byte does not disturb it.
        lcl_write(3'd6, 8'hC3);
        do_write_txn(8'h06, 0);
        i2c_start();
        send_byte(8'h51, 1'b1, "snap_addr_ack");
        fork
            read_byte(1'b0, d);
            begin
                wait_clk(3 * Q);
                lcl_write(3'd6, 8'h0F);
            end
        join
        chk("snap_rd", d, 8'hC3);
        model_ptr = 7;
        i2c_stop();
        check_regs("snap_regs");

        // Randomized traffic against the model.
        repeat (8) begin
            case ($urandom_range(0, 2))
                0: repeat ($urandom_range(1, 3))
                       lcl_write(AW'($urandom_range(0, NUM_REGS - 1)), 8'($urandom_range(0, 255)));
                1: do_write_txn(8'($urandom_range(0, 9)), $urandom_range(1, 4));
                default: do_read_txn($urandom_range(1, 3));
            endcase
        end
        check_regs("random_regs");

        // Reset while the target drives a 0 read bit.
        lcl_write(AW'(model_ptr), 8'h15);
        i2c_start();
        send_byte(8'h51, 1'b1, "rst_addr_r_ack");
        chk("rd_drive_zero", sda_oe, 1'b1);
        #3 rst_n = 1'b0;
        #1 chk("reset_async_release", sda_oe, 1'b0);
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        chk("reset_busy", busy, 1'b0);
        check_regs("reset_mid_regs");
        rst_n = 1'b1;
        wait_clk(4);
        i2c_stop();

        // Pointer returned to 0 after reset.
        lcl_write(3'd0, 8'h99);
        lcl_write(3'd1, 8'h44);
        do_read_txn(1);

        chk("oe_rise_while_scl_high", oe_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
